wb_arbiter: RTL

- Writeback stage directly upstream of the register file; merges two producers into its single write port.
- Producers: the ALU (single-cycle) and the memory unit (variable latency).
- Memory results take priority; ALU results that lose arbitration are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so issue logic can stall on RAW/WAW hazards.
- Drives the register file's write enable, destination address and write data from registered outputs.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 65 ++++++
 rtl/wb_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback arbiter.
package wb_pkg;

  localparam int unsigned DEF_LENGTH     = 32;
  localparam int unsigned DEF_NREGS      = 8;
  localparam int unsigned DEF_SEL_BITS   = $clog2(DEF_NREGS);
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef logic [DEF_SEL_BITS-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t             addr;
    logic [DEF_LENGTH-1:0] data;
  } wb_req_t;

  // Which producer drives the register file write this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_FIFO,
    SRC_ALU
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for ALU results that lose arbitration to memory.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_BITS = $clog2(DEPTH),
  localparam int unsigned CNT_BITS = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic [CNT_BITS-1:0] count,
  output logic                full,
  output logic                empty
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy next-state; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any buffered entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges memory and ALU results onto the single register
// file write port. Memory always wins; displaced ALU results queue in order.
// Also tracks which registers have a write pending for hazard stalls.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned LENGTH     = DEF_LENGTH,
  parameter int unsigned NREGS      = DEF_NREGS,
  parameter int unsigned SEL_BITS   = $clog2(NREGS),
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned CNT_BITS  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [SEL_BITS-1:0] alu_addr,
  input  logic [LENGTH-1:0]   alu_data,
  input  logic                mem_valid,
  input  logic [SEL_BITS-1:0] mem_addr,
  input  logic [LENGTH-1:0]   mem_data,
  input  logic                issue_valid,
  input  logic [SEL_BITS-1:0] issue_addr,
  output logic                rf_wr,
  output logic [SEL_BITS-1:0] rf_addr_d,
  output logic [LENGTH-1:0]   rf_data_in,
  output logic [NREGS-1:0]    busy_mask,
  output logic [CNT_BITS-1:0] fifo_count
);

  typedef struct packed {
    logic [SEL_BITS-1:0] addr;
    logic [LENGTH-1:0]   data;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  req_t    alu_req, mem_req, fifo_dout, sel_req;
  wb_src_t src;
  logic    alu_fire;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic                wr_en_q, wr_en_d;
  logic [SEL_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [LENGTH-1:0]   wr_data_q, wr_data_d;
  logic [NREGS-1:0]    busy_q, busy_d;

  // Acceptance depends on occupancy only: a full buffer refuses even if it
  // drains this cycle, keeping alu_ready free of any path from mem_valid.
  assign alu_ready = ~fifo_full;
  assign alu_fire  = alu_valid & alu_ready;
  assign alu_req   = '{addr: alu_addr, data: alu_data};
  assign mem_req   = '{addr: mem_addr, data: mem_data};

  wb_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (alu_req),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Source selection: memory, then buffered ALU, then ALU bypass.
  always_comb begin
    src       = SRC_NONE;
    sel_req   = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (mem_valid) begin
      src       = SRC_MEM;
      sel_req   = mem_req;
      fifo_push = alu_fire;
    end else if (!fifo_empty) begin
      src       = SRC_FIFO;
      sel_req   = fifo_dout;
      fifo_pop  = 1'b1;
      fifo_push = alu_fire;
    end else if (alu_fire) begin
      // Empty buffer: skip it so an idle pipe writes back with no extra cycle.
      src       = SRC_ALU;
      sel_req   = alu_req;
    end
  end

  // Output register next-state; address and data hold when nothing is chosen.
  always_comb begin
    wr_en_d   = (src != SRC_NONE);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (src != SRC_NONE) begin
      wr_addr_d = sel_req.addr;
      wr_data_d = sel_req.data;
    end
  end

  // Pending-write scoreboard: clear on the write leaving the output register,
  // then set on issue so a same-register collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q)     busy_d[wr_addr_q]  = 1'b0;
    if (issue_valid) busy_d[issue_addr] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_wr      = wr_en_q;
  assign rf_addr_d  = wr_addr_q;
  assign rf_data_in = wr_data_q;
  assign busy_mask  = busy_q;

endmodule
